// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU op codes, forward-select codes and lane defaults.
package execute_pkg;

  localparam int DEF_WIDTH        = 24;
  localparam int DEF_VECTOR_WIDTH = 8;
  localparam int SHAMT_BITS       = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_lane.sv
// One-word ALU shared by the scalar path and every vector lane.
// carry/overflow are meaningful for add/sub only and read 0 for every other op.
module alu_lane
  import execute_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0]            sum;
  logic [WIDTH:0]            diff;
  logic [SHAMT_BITS-1:0]     shamt;
  logic                      shift_oob;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign shamt     = b[SHAMT_BITS-1:0];
  assign shift_oob = 32'(shamt) >= 32'(WIDTH);

  always_comb begin
    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // carry is the no-borrow sense: set when a >= b unsigned
        y        = diff[WIDTH-1:0];
        carry    = ~diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = shift_oob ? '0 : (a << shamt);
      ALU_SRL: y = shift_oob ? '0 : (a >> shamt);
      ALU_MUL: y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute stage: operand forwarding, immediate select, scalar ALU, lane-wise vector ALU, NZVC flags.
// Define EXECUTE_FLAGS_REG_EN to register the flags on clk (async active-high rst, hold on vector ops).
module execute
  import execute_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    data1,
  input  logic [WIDTH-1:0]                    data2,
  input  logic [WIDTH-1:0]                    data3,
  input  logic [WIDTH-1:0]                    forwardM,
  input  logic [WIDTH-1:0]                    forwardWB,
  input  logic [2:0]                          ALUControlE,
  input  logic                                ALUSrcE,
  input  logic [1:0]                          data1ForwardSelector,
  input  logic [1:0]                          data2ForwardSelector,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  A,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  B,
  input  logic                                isvector,
  output logic [WIDTH-1:0]                    data2AfterForward,
  output logic [WIDTH-1:0]                    ALUResultE,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  Out_v,
  output logic                                N,
  output logic                                Z,
  output logic                                V,
  output logic                                C
);

  logic [WIDTH-1:0]        src_a;
  logic [WIDTH-1:0]        src_b;
  logic                    carry_s;
  logic                    ovf_s;
  logic [3:0]              flags_comb;
  logic [VECTOR_WIDTH-1:0] lane_carry_unused;
  logic [VECTOR_WIDTH-1:0] lane_ovf_unused;
  alu_op_e                 op;

  assign op = alu_op_e'(ALUControlE);

  // Reserved select 2'b11 falls back to the register value.
  always_comb begin
    case (fwd_sel_e'(data1ForwardSelector))
      FWD_WB:  src_a = forwardWB;
      FWD_MEM: src_a = forwardM;
      default: src_a = data1;
    endcase
    case (fwd_sel_e'(data2ForwardSelector))
      FWD_WB:  data2AfterForward = forwardWB;
      FWD_MEM: data2AfterForward = forwardM;
      default: data2AfterForward = data2;
    endcase
  end

  assign src_b = ALUSrcE ? data3 : data2AfterForward;

  alu_lane #(.WIDTH(WIDTH)) u_scalar (
    .a        (src_a),
    .b        (src_b),
    .op       (op),
    .y        (ALUResultE),
    .carry    (carry_s),
    .overflow (ovf_s)
  );

  for (genvar i = 0; i < VECTOR_WIDTH; i++) begin : g_lane
    alu_lane #(.WIDTH(WIDTH)) u_lane (
      .a        (A[i]),
      .b        (B[i]),
      .op       (op),
      .y        (Out_v[i]),
      .carry    (lane_carry_unused[i]),
      .overflow (lane_ovf_unused[i])
    );
  end

  assign flags_comb = {ALUResultE[WIDTH-1], ~|ALUResultE, ovf_s, carry_s};

`ifdef EXECUTE_FLAGS_REG_EN
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  always_comb begin
    flags_d = flags_comb;
    if (isvector) flags_d = flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign {N, Z, V, C} = flags_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk | rst;
  assign {N, Z, V, C}   = isvector ? 4'b0000 : flags_comb;
`endif

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed test-plan cases plus randomized scalar/vector ops vs an arithmetic model.
module tb_execute;

  localparam int    W    = 24;
  localparam int    VW   = 8;
  localparam longint MOD  = 64'd16777216;
  localparam longint HALF = 64'd8388608;

  logic                 clk;
  logic                 rst;
  logic [W-1:0]         data1, data2, data3, forwardM, forwardWB;
  logic [2:0]           ALUControlE;
  logic                 ALUSrcE;
  logic [1:0]           data1ForwardSelector, data2ForwardSelector;
  logic [VW-1:0][W-1:0] A, B, Out_v;
  logic                 isvector;
  logic [W-1:0]         data2AfterForward, ALUResultE;
  logic                 N, Z, V, C;

  int errors = 0;
  int checks = 0;
  logic [3:0] held;
  bit reg_build;

  execute dut (
    .clk                  (clk),
    .rst                  (rst),
    .data1                (data1),
    .data2                (data2),
    .data3                (data3),
    .forwardM             (forwardM),
    .forwardWB            (forwardWB),
    .ALUControlE          (ALUControlE),
    .ALUSrcE              (ALUSrcE),
    .data1ForwardSelector (data1ForwardSelector),
    .data2ForwardSelector (data2ForwardSelector),
    .A                    (A),
    .B                    (B),
    .isvector             (isvector),
    .data2AfterForward    (data2AfterForward),
    .ALUResultE           (ALUResultE),
    .Out_v                (Out_v),
    .N                    (N),
    .Z                    (Z),
    .V                    (V),
    .C                    (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   nzvc;
  } dvec_t;

  dvec_t dv [13] = '{
    '{3'd0, 24'h000001, 24'h000002, 24'h000003, 4'b0000},
    '{3'd1, 24'h000001, 24'h000002, 24'hFFFFFF, 4'b1000},
    '{3'd0, 24'h7FFFFF, 24'h000001, 24'h800000, 4'b1010},
    '{3'd0, 24'hFFFFFF, 24'h000001, 24'h000000, 4'b0101},
    '{3'd1, 24'h000005, 24'h000005, 24'h000000, 4'b0101},
    '{3'd1, 24'h800000, 24'h000001, 24'h7FFFFF, 4'b0011},
    '{3'd5, 24'h000001, 24'd23,     24'h800000, 4'b1000},
    '{3'd5, 24'h000001, 24'd24,     24'h000000, 4'b0100},
    '{3'd6, 24'h800000, 24'd23,     24'h000001, 4'b0000},
    '{3'd6, 24'hFFFFFF, 24'd31,     24'h000000, 4'b0100},
    '{3'd7, 24'h001000, 24'h001000, 24'h000000, 4'b0100},
    '{3'd2, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 4'b1000},
    '{3'd4, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 4'b0100}
  };

  // Returns {N,Z,V,C,result} from plain integer arithmetic on the unsigned/signed values.
  function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint ua, ub, sa, sb, full, sr, r;
    int amt;
    logic n, z, v, c;
    logic [W-1:0] rw;
    ua = a;
    ub = b;
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    amt = int'(ub % 32);
    v = 1'b0;
    c = 1'b0;
    r = 0;
    case (op)
      3'd0: begin
        full = ua + ub; r = full % MOD; c = (full >= MOD);
        sr = sa + sb;   v = (sr > HALF - 1) || (sr < -HALF);
      end
      3'd1: begin
        full = ua - ub; r = (full + MOD) % MOD; c = (ua >= ub);
        sr = sa - sb;   v = (sr > HALF - 1) || (sr < -HALF);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (amt >= W) ? 0 : (ua << amt) % MOD;
      3'd6: r = (amt >= W) ? 0 : (ua >> amt);
      default: r = (ua * ub) % MOD;
    endcase
    rw = r[W-1:0];
    n = (r >= HALF);
    z = (r == 0);
    return {n, z, v, c, rw};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_scalar(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic [W-1:0] d3, input logic [W-1:0] fm,
                              input logic [W-1:0] fwb, input logic [1:0] s1,
                              input logic [1:0] s2, input logic src);
    ALUControlE          = op;
    data1                = d1;
    data2                = d2;
    data3                = d3;
    forwardM             = fm;
    forwardWB            = fwb;
    data1ForwardSelector = s1;
    data2ForwardSelector = s2;
    ALUSrcE              = src;
    isvector             = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1;
    A = '0;
    B = '0;
    drive_scalar(3'd1, 24'd1, 24'd2, 24'd0, 24'd0, 24'd0, 2'b00, 2'b00, 1'b0);
    step();
    exp = reg_build ? 4'b0000 : 4'b1000;
    checks++;
    if (ALUResultE !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL reset_result got=%h exp=%h", ALUResultE, 24'hFFFFFF);
    end
    checks++;
    if ({N, Z, V, C} !== exp) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=%b", {N, Z, V, C}, exp);
    end
    rst  = 1'b0;
    held = 4'b0000;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 13; i++) begin
      drive_scalar(dv[i].op, dv[i].a, dv[i].b, 24'h0, 24'h0, 24'h0, 2'b00, 2'b00, 1'b0);
      step();
      checks++;
      if (ALUResultE !== dv[i].res) begin
        errors++;
        $display("FAIL directed_result[%0d] got=%h exp=%h", i, ALUResultE, dv[i].res);
      end
      checks++;
      if ({N, Z, V, C} !== dv[i].nzvc) begin
        errors++;
        $display("FAIL directed_flags[%0d] got=%b exp=%b", i, {N, Z, V, C}, dv[i].nzvc);
      end
      checks++;
      if (data2AfterForward !== dv[i].b) begin
        errors++;
        $display("FAIL directed_store[%0d] got=%h exp=%h", i, data2AfterForward, dv[i].b);
      end
      held = dv[i].nzvc;
    end
  endtask

  task automatic test_forwarding();
    logic [W-1:0] exp_res [4] = '{24'd9, 24'd7, 24'd3, 24'd14};
    logic [W-1:0] exp_st  [4] = '{24'd5, 24'd5, 24'd2, 24'd2};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive_scalar(3'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 2'b10, 2'b01, 1'b0);
        1: drive_scalar(3'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 2'b10, 2'b01, 1'b1);
        2: drive_scalar(3'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 2'b11, 2'b11, 1'b0);
        default: drive_scalar(3'd0, 24'd1, 24'd2, 24'd9, 24'd4, 24'd5, 2'b01, 2'b00, 1'b1);
      endcase
      step();
      checks++;
      if (ALUResultE !== exp_res[i]) begin
        errors++;
        $display("FAIL fwd_result[%0d] got=%h exp=%h", i, ALUResultE, exp_res[i]);
      end
      checks++;
      if (data2AfterForward !== exp_st[i]) begin
        errors++;
        $display("FAIL fwd_store[%0d] got=%h exp=%h", i, data2AfterForward, exp_st[i]);
      end
      held = 4'b0000;
    end
  endtask

  task automatic test_random_scalar();
    logic [W-1:0] opa, opb, st;
    logic [W+3:0] m;
    for (int i = 0; i < 200; i++) begin
      drive_scalar(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
                   W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (i % 5 == 0) data3 = W'($urandom_range(0, 31));
      opa = (data1ForwardSelector == 2'b01) ? forwardWB :
            (data1ForwardSelector == 2'b10) ? forwardM  : data1;
      st  = (data2ForwardSelector == 2'b01) ? forwardWB :
            (data2ForwardSelector == 2'b10) ? forwardM  : data2;
      opb = ALUSrcE ? data3 : st;
      m = ref_alu(ALUControlE, opa, opb);
      step();
      checks++;
      if (ALUResultE !== m[W-1:0] || data2AfterForward !== st) begin
        errors++;
        $display("FAIL rand_scalar[%0d] op=%0d got=%h/%h exp=%h/%h", i, ALUControlE,
                 ALUResultE, data2AfterForward, m[W-1:0], st);
      end
      checks++;
      if ({N, Z, V, C} !== m[W+3:W]) begin
        errors++;
        $display("FAIL rand_flags[%0d] op=%0d got=%b exp=%b", i, ALUControlE, {N, Z, V, C},
                 m[W+3:W]);
      end
      held = m[W+3:W];
    end
  endtask

  task automatic test_vector();
    logic [W+3:0] m;
    logic [W+3:0] ms;
    logic [3:0]   exp_f;
    for (int i = 0; i < 30; i++) begin
      drive_scalar(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
                   W'($urandom), W'($urandom), 2'b00, 2'b00, 1'b0);
      if (i < 2) begin
        ALUControlE = (i == 0) ? 3'd0 : 3'd7;
        for (int l = 0; l < VW; l++) begin
          A[l] = W'(VW - l);
          B[l] = W'(VW - l);
        end
      end else begin
        for (int l = 0; l < VW; l++) begin
          A[l] = W'($urandom);
          B[l] = (l % 3 == 0) ? W'($urandom_range(0, 31)) : W'($urandom);
        end
      end
      isvector = 1'b1;
      ms = ref_alu(ALUControlE, data1, data2);
      step();
      if (i == 0) begin
        checks++;
        if (Out_v[0] !== 24'h10 || Out_v[7] !== 24'h2) begin
          errors++;
          $display("FAIL vec_add_plan got=%h,%h exp=10,2", Out_v[0], Out_v[7]);
        end
      end
      if (i == 1) begin
        checks++;
        if (Out_v[0] !== 24'h40 || Out_v[7] !== 24'h1) begin
          errors++;
          $display("FAIL vec_mul_plan got=%h,%h exp=40,1", Out_v[0], Out_v[7]);
        end
      end
      for (int l = 0; l < VW; l++) begin
        m = ref_alu(ALUControlE, A[l], B[l]);
        checks++;
        if (Out_v[l] !== m[W-1:0]) begin
          errors++;
          $display("FAIL vec_lane[%0d][%0d] op=%0d got=%h exp=%h", i, l, ALUControlE, Out_v[l],
                   m[W-1:0]);
        end
      end
      checks++;
      if (ALUResultE !== ms[W-1:0]) begin
        errors++;
        $display("FAIL vec_scalar_result[%0d] got=%h exp=%h", i, ALUResultE, ms[W-1:0]);
      end
      exp_f = reg_build ? held : 4'b0000;
      checks++;
      if ({N, Z, V, C} !== exp_f) begin
        errors++;
        $display("FAIL vec_flags[%0d] got=%b exp=%b", i, {N, Z, V, C}, exp_f);
      end
    end
    isvector = 1'b0;
  endtask

`ifdef EXECUTE_FLAGS_REG_EN
  task automatic test_flags_reg();
    drive_scalar(3'd1, 24'd1, 24'd2, 24'd0, 24'd0, 24'd0, 2'b00, 2'b00, 1'b0);
    step();
    checks++;
    if ({N, Z, V, C} !== 4'b1000) begin
      errors++;
      $display("FAIL reg_pre_reset got=%b exp=1000", {N, Z, V, C});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({N, Z, V, C} !== 4'b0000) begin
      errors++;
      $display("FAIL reg_async_reset got=%b exp=0000", {N, Z, V, C});
    end
    @(negedge clk);
    rst = 1'b0;
    drive_scalar(3'd1, 24'd5, 24'd5, 24'd0, 24'd0, 24'd0, 2'b00, 2'b00, 1'b0);
    #1;
    checks++;
    if ({N, Z, V, C} !== 4'b0000) begin
      errors++;
      $display("FAIL reg_before_edge got=%b exp=0000", {N, Z, V, C});
    end
    step();
    checks++;
    if ({N, Z, V, C} !== 4'b0101) begin
      errors++;
      $display("FAIL reg_after_edge got=%b exp=0101", {N, Z, V, C});
    end
    drive_scalar(3'd0, 24'h7FFFFF, 24'd1, 24'd0, 24'd0, 24'd0, 2'b00, 2'b00, 1'b0);
    isvector = 1'b1;
    step();
    checks++;
    if ({N, Z, V, C} !== 4'b0101) begin
      errors++;
      $display("FAIL reg_vector_hold got=%b exp=0101", {N, Z, V, C});
    end
    isvector = 1'b0;
    step();
    checks++;
    if ({N, Z, V, C} !== 4'b1010) begin
      errors++;
      $display("FAIL reg_resume got=%b exp=1010", {N, Z, V, C});
    end
  endtask
`endif

  initial begin
`ifdef EXECUTE_FLAGS_REG_EN
    reg_build = 1'b1;
`else
    reg_build = 1'b0;
`endif
    held = 4'b0000;
    test_reset();
    test_directed();
    test_forwarding();
    test_random_scalar();
    test_vector();
`ifdef EXECUTE_FLAGS_REG_EN
    test_flags_reg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the pipelined scalar/vector processor: resolves operand forwarding, selects immediate vs register operand, runs one scalar ALU and a VECTOR_WIDTH-lane vector ALU, and produces condition flags. Sits between the ID/EX and EX/MEM pipeline registers. The datapath is combinational; clock and reset are used only for the optional flag register.

## Interface
- WIDTH, 24, bits per scalar word and per vector lane
- VECTOR_WIDTH, 8, number of vector lanes
- clk  in  1  clock; used only when EXECUTE_FLAGS_REG_EN is defined
- rst  in  1  reset; asynchronous, active-high
- data1, data2  in  WIDTH  register-file operands A and B
- data3  in  WIDTH  extended immediate
- forwardM  in  WIDTH  forwarded ALU result from MEM stage
- forwardWB  in  WIDTH  forwarded result from WB stage
- ALUControlE  in  3  operation select
- ALUSrcE  in  1  1 = operand B is data3
- data1ForwardSelector, data2ForwardSelector  in  2  forward select per operand
- A, B  in  [VECTOR_WIDTH-1:0][WIDTH-1:0]  vector operands, lane 0 = LSBs
- isvector  in  1  1 = vector instruction
- data2AfterForward  out  WIDTH  forwarded operand B before the immediate mux (store data)
- ALUResultE  out  WIDTH  scalar result
- Out_v  out  [VECTOR_WIDTH-1:0][WIDTH-1:0]  lane-wise vector result
- N, Z, V, C  out  1  negative, zero, overflow, carry flags

## Operation
- Forward mux per operand: 00 = register value, 01 = forwardWB, 10 = forwardM, 11 = register value (reserved).
- srcA = forwarded data1; data2AfterForward = forwarded data2; srcB = ALUSrcE ? data3 : data2AfterForward.
- ALUControlE: 000 add, 001 sub (srcA−srcB), 010 and, 011 or, 100 xor, 101 shift left logical, 110 shift right logical, 111 multiply (low WIDTH bits of the product).
- Shift amount = srcB[4:0]; an amount ≥ WIDTH yields 0.
- All arithmetic is modulo 2^WIDTH, two's complement.
- Vector: Out_v[i] = A[i] op B[i] for every lane, same op codes. The vector ALU ignores forwarding and ALUSrcE. Lanes are independent, with no carry between them.
- ALUResultE is always the scalar result. Out_v is always the vector result. Both are driven regardless of isvector.
- Flags come from the scalar result only:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = carry out for add; for sub, C = no-borrow (srcA ≥ srcB unsigned).
  - V = signed overflow for add/sub.
  - For ops 010–111, C = V = 0.
- When isvector = 1, all flags = 0.

## Timing
- Without EXECUTE_FLAGS_REG_EN, all outputs are combinational, with zero-cycle latency. clk and rst are unused.
- With EXECUTE_FLAGS_REG_EN:
  - N/Z/V/C are registered on the rising edge of clk.
  - During rst: N/Z/V/C = 0, taking effect immediately (asynchronous).
  - During isvector = 1, the flags hold their previous value.
  - Flags update on the first edge after rst deasserts.
- Result outputs stay combinational in both modes, and have no reset value.

## Configuration
- EXECUTE_FLAGS_REG_EN:
  - Defined: flags are registered as described in Timing.
  - Undefined: flags are combinational, and forced to 0 for vector ops.

## Structure
- Package execute_pkg holds alu_op_e (the 3-bit op enum above) and fwd_sel_e (FWD_REG, FWD_WB, FWD_MEM).
- Sub-module alu_lane: a one-word ALU with carry/overflow outputs. It is instantiated once for the scalar path and VECTOR_WIDTH times through a generate loop.

## Test plan
- data1=1, data2=2, both selectors 00, ALUSrcE=0, op 000 -> ALUResultE=3, data2AfterForward=2, NZVC=0000.
- Same operands, op 001 -> ALUResultE=0xFFFFFF, N=1, Z=0, C=0, V=0.
- Forwarding, op 000:
  - Setup: data1ForwardSelector=10, data2ForwardSelector=01, forwardM=4, forwardWB=5.
  - Expected: ALUResultE=9, data2AfterForward=5.
  - With ALUSrcE=1 and data3=3 instead: ALUResultE=7, data2AfterForward=5.
- Overflow and zero:
  - 0x7FFFFF + 1 -> 0x800000, N=1, V=1, C=0.
  - 0xFFFFFF + 1 -> 0, Z=1, C=1.
- Vector, isvector=1, A=B={1,2,...,8} with lane 0 = 8:
  - op 000 -> lane0=0x10, lane7=2.
  - op 111 -> lane0=0x40, lane7=1.
  - NZVC=0000 in the combinational build.
- Registered build:
  - rst=1 mid-run -> flags 0 immediately.
  - After release, a sub with result 0 -> Z=1 after the next clk edge.
  - A following vector op -> flags unchanged.
